// File: rtl/output_interface_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : output_interface_pkg
//  Purpose  : Shared FSM encoding and block geometry for the AES byte streams.
//  Revision : 1.0  initial release
// ============================================================================
package output_interface_pkg;

    localparam int STATE_W = 2;
    typedef logic [STATE_W-1:0] state_t;

    localparam state_t S_IDLE = 2'd0;
    localparam state_t S_SEND = 2'd1;
    localparam state_t S_DONE = 2'd2;

    localparam int BLOCK_W      = 128;
    localparam int BYTE_W       = 8;
    localparam int BLOCK_NBYTES = 16;
    localparam int CNT_W        = 4;

    // Bytes leave MSB-first, so the outgoing byte is always the top slice.
    function automatic logic [BYTE_W-1:0] top_byte(input logic [BLOCK_W-1:0] v);
        return v[BLOCK_W-1 -: BYTE_W];
    endfunction

endpackage
`default_nettype wire

// File: rtl/output_interface_if.sv
`default_nettype none
// ============================================================================
//  Module   : output_interface_if
//  Purpose  : Engine-to-host ciphertext byte stream bundle.
//  Revision : 1.0  initial release
// ============================================================================
interface output_interface_if;
    import output_interface_pkg::*;

    logic               engine_done;
    logic [BLOCK_W-1:0] cipher_in;
    logic [BYTE_W-1:0]  dout;
    logic               dout_valid;
    logic               dout_ready;
    logic               busy;
    logic               last;
    logic               overrun;

    modport master (
        input  engine_done,
        input  cipher_in,
        input  dout_ready,
        output dout,
        output dout_valid,
        output busy,
        output last,
        output overrun
    );

    modport slave (
        output engine_done,
        output cipher_in,
        output dout_ready,
        input  dout,
        input  dout_valid,
        input  busy,
        input  last,
        input  overrun
    );

endinterface
`default_nettype wire

// File: rtl/output_interface.sv
`default_nettype none
// ============================================================================
//  Module   : output_interface
//  Purpose  : Holds one 128-bit ciphertext block and streams it MSB-first as
//             bytes over a valid/ready handshake.
//  Revision : 1.0  initial release
// ============================================================================
module output_interface
    import output_interface_pkg::*;
#(
    parameter int NBYTES = BLOCK_NBYTES
) (
    input  logic               clk,
    input  logic               rst_,
    output_interface_if.master bus
);

    localparam logic [CNT_W-1:0] C_LAST_IDX = CNT_W'(NBYTES - 1);

    state_t             state_q,   state_d;
    logic [BLOCK_W-1:0] shift_q,   shift_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;
    logic               overrun_q, overrun_d;

    logic               w_valid;
    logic               w_last;
    logic               w_handshake;

    always_ff @(posedge clk) begin
        if (rst_) begin
            state_q   <= S_IDLE;
            shift_q   <= '0;
            cnt_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        // A second block arriving mid-stream is dropped; only the flag records it.
        overrun_d = overrun_q || (bus.engine_done && (state_q != S_IDLE));

        case (state_q)
            S_IDLE: begin
                if (bus.engine_done) begin
                    shift_d = bus.cipher_in;
                    cnt_d   = '0;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (w_handshake) begin
                    shift_d = {shift_q[BLOCK_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
                    if (w_last) begin
                        cnt_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // valid/last depend only on registered state, never on dout_ready.
    always_comb begin
        w_valid        = (state_q == S_SEND);
        w_last         = w_valid && (cnt_q == C_LAST_IDX);
        w_handshake    = w_valid && bus.dout_ready;

        bus.dout       = top_byte(shift_q);
        bus.dout_valid = w_valid;
        bus.last       = w_last;
        bus.busy       = (state_q != S_IDLE) || bus.engine_done;
        bus.overrun    = overrun_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_output_interface.sv
`default_nettype none
// ============================================================================
//  Module   : tb_output_interface
//  Purpose  : Scoreboard bench for the ciphertext byte streamer.
//  Revision : 1.0  initial release
// ============================================================================
module tb_output_interface;

    localparam logic [127:0] C_BLK_A = 128'h00112233445566778899AABBCCDDEEFF;
    localparam logic [127:0] C_BLK_B = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;
    localparam logic [127:0] C_ONES  = {128{1'b1}};
    localparam logic [127:0] C_FOOD  = {4{32'hF00DBABE}};

    logic clk = 1'b0;
    logic rst_;
    always #5 clk = ~clk;

    output_interface_if bif ();

    output_interface #(.NBYTES(16)) dut (
        .clk  (clk),
        .rst_ (rst_),
        .bus  (bif.master)
    );

    int         total = 0;
    int         bad   = 0;
    int         hs_cnt = 0;
    logic [8:0] exp_q[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Expected stream entry = {last, byte}, MSB-first.
    task automatic push_block(input logic [127:0] blk);
        logic [127:0] b;
        b = blk;
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back({(i == 15), b[127:120]});
            b = b << 8;
        end
    endtask

    task automatic monitor();
        logic [8:0] prev_v;
        logic [8:0] e;
        bit         prev_stall;
        prev_stall = 1'b0;
        prev_v     = '0;
        forever begin
            @(negedge clk);
            if (!rst_ && prev_stall && bif.dout_valid)
                chk("stall_hold", {bif.last, bif.dout}, prev_v);
            if (!rst_ && bif.dout_valid && bif.dout_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_byte", {bif.last, bif.dout}, 9'h1FF);
                end else begin
                    e = exp_q.pop_front();
                    chk("stream_byte", {bif.last, bif.dout}, e);
                end
                hs_cnt++;
            end
            prev_stall = !rst_ && bif.dout_valid && !bif.dout_ready;
            prev_v     = {bif.last, bif.dout};
        end
    endtask

    // Called at #1 after a rising edge; returns at #1 after the capture edge.
    task automatic pulse(input logic [127:0] blk, input bit accept);
        bif.cipher_in   = blk;
        bif.engine_done = 1'b1;
        if (accept) push_block(blk);
        #1;
        chk("busy_on_pulse", bif.busy, 1'b1);
        @(posedge clk);
        #1;
        bif.engine_done = 1'b0;
        chk("valid_after_pulse", bif.dout_valid, 1'b1);
    endtask

    task automatic wait_hs(input int n, input int budget);
        int k;
        k = 0;
        while (hs_cnt < n && k < budget) begin
            @(posedge clk);
            k++;
        end
        #1;
        if (hs_cnt < n) chk("wait_hs_timeout", hs_cnt, n);
    endtask

    task automatic wait_drain(input int budget);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || bif.busy) && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("drain_timeout", {exp_q.size() != 0, bif.busy}, 2'b00);
    endtask

    initial begin
        int base;
        int i;
        bif.engine_done = 1'b0;
        bif.cipher_in   = '0;
        bif.dout_ready  = 1'b0;
        rst_            = 1'b1;
        fork
            monitor();
        join_none

        // Reset with engine_done held high: reset must win.
        bif.engine_done = 1'b1;
        bif.cipher_in   = C_BLK_A;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid_with_done", bif.dout_valid, 1'b0);
        bif.engine_done = 1'b0;
        #1;
        chk("rst_dout",    bif.dout,    8'h00);
        chk("rst_last",    bif.last,    1'b0);
        chk("rst_busy",    bif.busy,    1'b0);
        chk("rst_overrun", bif.overrun, 1'b0);
        chk("rst_cnt",     dut.cnt_q,   4'h0);
        rst_ = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_after_reset", bif.dout_valid, 1'b0);

        // Basic stream with exact latency checks.
        bif.dout_ready = 1'b1;
        pulse(C_BLK_A, 1'b1);
        for (int c = 2; c <= 18; c++) begin
            @(posedge clk);
            #1;
            if (c == 16) chk("last_byte_n16", {bif.last, bif.dout}, 9'h1FF);
            if (c == 17) chk("done_n17", {bif.busy, bif.dout_valid}, 2'b10);
            if (c == 18) chk("busy_fall_n18", bif.busy, 1'b0);
        end
        wait_drain(10);

        // Backpressure: ready pattern 1,0,0 repeating.
        bif.dout_ready = 1'b0;
        pulse(C_BLK_A, 1'b1);
        i = 0;
        while (exp_q.size() != 0 && i < 300) begin
            bif.dout_ready = (i % 3 == 0);
            @(posedge clk);
            #1;
            i++;
        end
        bif.dout_ready = 1'b1;
        wait_drain(20);

        // Overrun after the 5th byte.
        base = hs_cnt;
        pulse(C_BLK_A, 1'b1);
        wait_hs(base + 5, 40);
        pulse(C_ONES, 1'b0);
        chk("overrun_set", bif.overrun, 1'b1);
        wait_drain(40);
        repeat (3) @(posedge clk);
        #1;
        chk("overrun_sticky", bif.overrun, 1'b1);

        // Mid-stream reset after byte 8.
        base = hs_cnt;
        pulse(C_BLK_A, 1'b1);
        wait_hs(base + 8, 40);
        chk("overrun_before_rst", bif.overrun, 1'b1);
        rst_ = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        chk("midrst_valid",   bif.dout_valid, 1'b0);
        chk("midrst_busy",    bif.busy,       1'b0);
        chk("midrst_overrun", bif.overrun,    1'b0);
        rst_ = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_no_bytes", bif.dout_valid, 1'b0);
        pulse(C_FOOD, 1'b1);
        chk("food_first_byte", bif.dout, 8'hF0);
        wait_drain(40);

        // Back-to-back: second pulse on the idle cycle right after S_DONE.
        pulse(C_BLK_A, 1'b1);
        repeat (17) @(posedge clk);
        #1;
        chk("b2b_idle_gap", bif.busy, 1'b0);
        pulse(C_BLK_B, 1'b1);
        wait_drain(40);
        chk("b2b_no_overrun", bif.overrun, 1'b0);

        // Idle ready: no effect without a block.
        bif.dout_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            chk("idle_ready", {bif.dout_valid, bif.busy, dut.cnt_q}, 6'h00);
        end

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/output_interface.md
OUTPUT_INTERFACE -- requirements
Module: output_interface

Interface
REQ-001 The block SHALL have one parameter: NBYTES, default 16, the number of bytes per ciphertext block (fixed at 16 for AES-128).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port engine_done, input, 1 bit: a one-cycle pulse from the engine meaning cipher_in is valid this cycle.
REQ-005 The block SHALL have port cipher_in, input, 128 bits: the ciphertext from the engine.
REQ-006 The block SHALL have port dout, output, 8 bits: the current output byte.
REQ-007 The block SHALL have port dout_valid, output, 1 bit: dout holds a valid byte.
REQ-008 The block SHALL have port dout_ready, input, 1 bit: the host accepts the byte this cycle.
REQ-009 The block SHALL have port busy, output, 1 bit: a block is being held or streamed.
REQ-010 The block SHALL have port last, output, 1 bit: the byte on dout is the final byte of the block, qualified by dout_valid.
REQ-011 The block SHALL have port overrun, output, 1 bit: sticky flag set when engine_done arrives while busy.

Function
REQ-012 The FSM SHALL have states S_IDLE, S_SEND and S_DONE, with state encoding defined in the package.
REQ-013 In S_IDLE, engine_done=1 SHALL capture cipher_in into a 128-bit shift register, clear the byte counter to 0, and enter S_SEND on the next cycle.
REQ-014 In S_SEND, dout SHALL equal shift-register bits [127:120], so bytes go out MSB-first, matching the MSB-first load order of input_interface.
REQ-015 dout_valid SHALL be 1 exactly when state==S_SEND, with no combinational path from dout_ready to dout_valid.
REQ-016 A handshake SHALL occur when dout_valid and dout_ready are both 1; on a handshake the register shifts left by 8 bits (zero fill) and the counter increments.
REQ-017 When there is no handshake, dout, last and the counter SHALL hold their values.
REQ-018 last SHALL be 1 when state==S_SEND and counter==NBYTES-1.
REQ-019 A handshake while last=1 SHALL move the FSM to S_DONE, and the counter SHALL wrap to 0.
REQ-020 S_DONE SHALL last exactly one cycle (dout_valid=0, busy=1) and then return to S_IDLE.
REQ-021 busy SHALL be 1 in S_SEND and S_DONE, and also in the S_IDLE cycle in which engine_done is captured.
REQ-022 Latency SHALL be as follows: engine_done on cycle N puts the first byte valid on cycle N+1; with dout_ready held at 1, the last byte is on N+16 and busy falls on N+18.
REQ-023 engine_done while in S_SEND or S_DONE SHALL be ignored for data (the block in progress is not corrupted) and SHALL set overrun to 1.
REQ-024 overrun SHALL stay set until reset.
REQ-025 dout_ready asserted while dout_valid=0 SHALL have no effect.
REQ-026 The byte counter SHALL be 4 bits wide and SHALL never exceed NBYTES-1.

Reset
REQ-027 When rst_=1 at a clock edge, the block SHALL take: state=S_IDLE, shift register=0, counter=0, dout=0x00, dout_valid=0, last=0, busy=0, overrun=0.
REQ-028 Reset SHALL take priority over engine_done and over any handshake.
REQ-029 Reset asserted in mid-stream SHALL abort the block with no further bytes, and the next engine_done SHALL start a fresh block.

Structure
REQ-030 A shared package SHALL hold the state localparams (S_IDLE, S_SEND, S_DONE), the block width 128 and NBYTES 16, for reuse by input_interface and the top level.
REQ-031 The block SHALL be a single module with no sub-module; the shift register and counter are inline.

Verification
REQ-032 Basic stream: cipher_in=0x00112233445566778899AABBCCDDEEFF, pulse engine_done, dout_ready=1 -> bytes 0x00,0x11,...,0xFF on consecutive cycles, last only on 0xFF, busy low two cycles after the 0xFF handshake.
REQ-033 Backpressure: same data, dout_ready toggling 1,0,0,1,... -> dout holds its value across stalled cycles, 16 bytes delivered in order with none lost or duplicated.
REQ-034 Overrun: engine_done pulsed again with cipher_in=all-ones after the 5th byte -> the original bytes 6 to 16 are unchanged, overrun=1 and stays 1 after the block completes.
REQ-035 Mid-stream reset: rst_=1 after byte 8 -> next cycle dout_valid=0, busy=0, overrun=0; a new engine_done with 0xF00DBABE repeated streams 0xF0,0x0D,... from byte 0.
REQ-036 Back-to-back blocks: second engine_done exactly on the S_IDLE cycle after S_DONE -> second block accepted, overrun stays 0.
REQ-037 Idle ready: dout_ready=1 with no engine_done for 20 cycles -> dout_valid=0, busy=0 and the counter stays 0 throughout.
